// File: rtl/serial_add_seq_if.sv
// Request/result and external full-adder signals of the bit-serial adder.
interface serial_add_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;

   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   logic             busy;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             done;

   // Requester side: issues operands, observes status and result.
   modport master (
      output start, a, b, c_in,
      input  busy, sum, c_out, done
   );

   // Sequencer side: drives the full adder one bit per cycle.
   modport slave (
      input  start, a, b, c_in, fa_sum, fa_cout,
      output fa_a, fa_b, fa_cin, busy, sum, c_out, done
   );

   // External combinational full adder.
   modport adder (
      input  fa_a, fa_b, fa_cin,
      output fa_sum, fa_cout
   );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder: feeds one operand bit pair per cycle, LSB first, through an
// external full adder and assembles {c_out, sum} = a + b + c_in.
module serial_add_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   serial_add_seq_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             c_out_q;
   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    count_q;

   logic             in_shift;
   logic [WIDTH-1:0] acc_d;

   // Full-adder operands come only from registers so start/a/b cannot reach them.
   assign in_shift   = (state_q == SHIFT);
   assign bus.fa_a   = in_shift & a_sh_q[0];
   assign bus.fa_b   = in_shift & b_sh_q[0];
   assign bus.fa_cin = in_shift & carry_q;

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
   assign acc_d = (acc_q >> 1) | (WIDTH'(bus.fa_sum) << (WIDTH - 1));

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;

   // Sequencer: capture operands, shift WIDTH times, publish result for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_sh_q  <= bus.a;
                  b_sh_q  <= bus.b;
                  carry_q <= bus.c_in;
                  count_q <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               acc_q   <= acc_d;
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               carry_q <= bus.fa_cout;
               count_q <= count_q + CW'(1);
               if (count_q == LAST) begin
                  sum_q   <= acc_d;
                  c_out_q <= bus.fa_cout;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
